// File: rtl/mailbox_pkg.sv
// Shared constants for the multi-channel APB mailbox:
// register offsets, STATUS bit positions, config checks.
package mailbox_pkg;

   localparam int unsigned OFS_TX_DATA = 'h00;
   localparam int unsigned OFS_TX_DEST = 'h04;
   localparam int unsigned OFS_RX_DATA = 'h08;
   localparam int unsigned OFS_STATUS  = 'h0C;
   localparam int unsigned OFS_IRQ_THR = 'h10;
   localparam int unsigned OFS_RX_SRC  = 'h14;
   localparam int unsigned OFS_DROP    = 'h18;

   localparam int ST_EMPTY = 16;
   localparam int ST_FULL  = 17;
   localparam int ST_DFULL = 18;
   localparam int ST_DINV  = 19;

   typedef enum logic [2:0] {
      R_TX_DATA,
      R_TX_DEST,
      R_RX_DATA,
      R_STATUS,
      R_IRQ_THR,
      R_RX_SRC,
      R_DROP,
      R_NONE
   } reg_sel_t;

   function automatic bit pow2(int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   function automatic bit cfg_ok(int n, int w, int a, int k);
      return (n >= 1) && (n <= 16) &&
             (w >= 8) && (w <= 1024) && pow2(w) &&
             (a >= 5) &&
             (k >= 2) && (k <= 1024) && pow2(k);
   endfunction

endpackage

// File: rtl/mbx_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at ptr,
// ptr moves to grant+1 whenever a grant is issued.
module mbx_rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   output logic [N-1:0] grant
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_nxt;

   // first requester at or after ptr (circularly) wins
   always_comb begin : p_pick
      int  idx;
      logic found;
      grant   = '0;
      ptr_nxt = ptr;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            ptr_nxt    = (idx == N - 1) ? '0 : PW'(idx + 1);
         end
      end
   end

   // rotation pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr <= '0;
      else        ptr <= ptr_nxt;
   end

endmodule

// File: rtl/mailbox_mc_apb.sv
// Multi-channel APB mailbox, one RX FIFO per CPU port.
// Optional MAILBOX_DROP_CNT_EN adds per-CPU drop counters at 0x18.
module mailbox_mc_apb
   import mailbox_pkg::*;
#(
   parameter int N_NUMB_CPU   = 4,
   parameter int W_WIDTH_SYS  = 32,
   parameter int WIDTH_ADDR   = 8,
   parameter int K_FIFO_DEPTH = 16
) (
   input  logic                                   pclk_i,
   input  logic                                   presetn_i,
   input  logic [N_NUMB_CPU-1:0]                  psel_i,
   input  logic [N_NUMB_CPU-1:0]                  penable_i,
   input  logic [N_NUMB_CPU-1:0]                  pwrite_i,
   input  logic [N_NUMB_CPU-1:0][WIDTH_ADDR-1:0]  paddr_i,
   input  logic [N_NUMB_CPU-1:0][W_WIDTH_SYS-1:0] pwdata_i,
   output logic [N_NUMB_CPU-1:0][W_WIDTH_SYS-1:0] prdata_o,
   output logic [N_NUMB_CPU-1:0]                  pready_o,
   output logic [N_NUMB_CPU-1:0]                  pslverr_o,
   output logic [N_NUMB_CPU-1:0]                  irq_o
);

   localparam int N     = N_NUMB_CPU;
   localparam int W     = W_WIDTH_SYS;
   localparam int K     = K_FIFO_DEPTH;
   localparam int SRC_W = (N > 1) ? $clog2(N) : 1;
   localparam int PTR_W = $clog2(K);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = W + SRC_W;

   localparam logic [WIDTH_ADDR-1:0] A_TX_DATA = WIDTH_ADDR'(OFS_TX_DATA);
   localparam logic [WIDTH_ADDR-1:0] A_TX_DEST = WIDTH_ADDR'(OFS_TX_DEST);
   localparam logic [WIDTH_ADDR-1:0] A_RX_DATA = WIDTH_ADDR'(OFS_RX_DATA);
   localparam logic [WIDTH_ADDR-1:0] A_STATUS  = WIDTH_ADDR'(OFS_STATUS);
   localparam logic [WIDTH_ADDR-1:0] A_IRQ_THR = WIDTH_ADDR'(OFS_IRQ_THR);
   localparam logic [WIDTH_ADDR-1:0] A_RX_SRC  = WIDTH_ADDR'(OFS_RX_SRC);
   localparam logic [WIDTH_ADDR-1:0] A_DROP    = WIDTH_ADDR'(OFS_DROP);

   if (!cfg_ok(N_NUMB_CPU, W_WIDTH_SYS, WIDTH_ADDR, K_FIFO_DEPTH)) begin : g_bad_cfg
      $error("mailbox_mc_apb: illegal parameter set");
   end

   function automatic reg_sel_t decode(logic [WIDTH_ADDR-1:0] a);
      reg_sel_t s;
      case (a)
         A_TX_DATA: s = R_TX_DATA;
         A_TX_DEST: s = R_TX_DEST;
         A_RX_DATA: s = R_RX_DATA;
         A_STATUS:  s = R_STATUS;
         A_IRQ_THR: s = R_IRQ_THR;
         A_RX_SRC:  s = R_RX_SRC;
`ifdef MAILBOX_DROP_CNT_EN
         A_DROP:    s = R_DROP;
`else
         A_DROP:    s = R_NONE;
`endif
         default:   s = R_NONE;
      endcase
      return s;
   endfunction

   logic [ENT_W-1:0]            mem [N][K];
   logic [N-1:0][PTR_W-1:0]     wptr;
   logic [N-1:0][PTR_W-1:0]     rptr;
   logic [N-1:0][CNT_W-1:0]     cnt;
   logic [N-1:0][SRC_W-1:0]     tx_dest;
   logic [N-1:0][CNT_W-1:0]     irq_thr;

   reg_sel_t                    sel [N];
   logic [ENT_W-1:0]            head [N];
   logic [N-1:0]                acc, req, grant;
   logic [N-1:0]                empty, full, dest_inv, dest_full;
   logic [N-1:0]                pop, push, wr_dest, wr_thr;
   logic [N-1:0][ENT_W-1:0]     push_ent;

`ifdef MAILBOX_DROP_CNT_EN
   logic [N-1:0][15:0]          drop_cnt;
   logic [N-1:0]                drop_inc, clr_drop;
`endif

   // per-port decode, FIFO flags and TX destination checks
   always_comb begin
      for (int i = 0; i < N; i++) begin
         acc[i]       = psel_i[i] & penable_i[i];
         sel[i]       = decode(paddr_i[i]);
         req[i]       = acc[i] & pwrite_i[i] & (sel[i] == R_TX_DATA);
         head[i]      = mem[i][rptr[i]];
         empty[i]     = (cnt[i] == '0);
         full[i]      = (cnt[i] == CNT_W'(K));
         dest_inv[i]  = (int'(tx_dest[i]) >= N);
         dest_full[i] = 1'b0;
         for (int j = 0; j < N; j++)
            if (int'(tx_dest[i]) == j) dest_full[i] = full[j];
      end
   end

   mbx_rr_arbiter #(.N(N)) u_arb (
      .clk   (pclk_i),
      .rst_n (presetn_i),
      .req   (req),
      .grant (grant)
   );

   // route the single granted word to its destination FIFO
   always_comb begin
      push     = '0;
      push_ent = '0;
`ifdef MAILBOX_DROP_CNT_EN
      drop_inc = '0;
`endif
      for (int i = 0; i < N; i++) begin
         if (grant[i] && !dest_inv[i]) begin
            for (int j = 0; j < N; j++) begin
               if (int'(tx_dest[i]) == j) begin
                  if (!full[j]) begin
                     push[j]     = 1'b1;
                     push_ent[j] = {SRC_W'(i), pwdata_i[i]};
                  end
`ifdef MAILBOX_DROP_CNT_EN
                  else drop_inc[j] = 1'b1;
`endif
               end
            end
         end
      end
   end

   // APB response: ready, error, read data and register strobes
   always_comb begin
      prdata_o  = '0;
      pready_o  = '0;
      pslverr_o = '0;
      pop       = '0;
      wr_dest   = '0;
      wr_thr    = '0;
`ifdef MAILBOX_DROP_CNT_EN
      clr_drop  = '0;
`endif
      for (int i = 0; i < N; i++) begin
         if (acc[i] && presetn_i) begin
            pready_o[i] = 1'b1;
            unique case (sel[i])
               R_TX_DATA: begin
                  if (pwrite_i[i]) begin
                     pready_o[i]  = grant[i];
                     pslverr_o[i] = grant[i] & (dest_inv[i] | dest_full[i]);
                  end else begin
                     pslverr_o[i] = 1'b1;
                  end
               end
               R_TX_DEST: begin
                  if (pwrite_i[i]) wr_dest[i] = 1'b1;
                  else prdata_o[i] = W'(tx_dest[i]);
               end
               R_RX_DATA: begin
                  if (pwrite_i[i] || empty[i]) begin
                     pslverr_o[i] = 1'b1;
                  end else begin
                     prdata_o[i] = head[i][W-1:0];
                     pop[i]      = 1'b1;
                  end
               end
               R_STATUS: begin
                  if (pwrite_i[i]) pslverr_o[i] = 1'b1;
                  else prdata_o[i] = W'({12'd0,
                                         dest_inv[i],
                                         dest_full[i],
                                         full[i],
                                         empty[i],
                                         16'(cnt[i])});
               end
               R_IRQ_THR: begin
                  if (pwrite_i[i]) wr_thr[i] = 1'b1;
                  else prdata_o[i] = W'(irq_thr[i]);
               end
               R_RX_SRC: begin
                  if (pwrite_i[i]) pslverr_o[i] = 1'b1;
                  else if (!empty[i])
                     prdata_o[i] = W'(head[i][ENT_W-1:W]);
               end
`ifdef MAILBOX_DROP_CNT_EN
               R_DROP: begin
                  if (pwrite_i[i]) clr_drop[i] = 1'b1;
                  else prdata_o[i] = W'(drop_cnt[i]);
               end
`endif
               default: pslverr_o[i] = 1'b1;
            endcase
         end
      end
   end

   // FIFO storage, written only on an accepted push
   always_ff @(posedge pclk_i) begin
      for (int i = 0; i < N; i++)
         if (push[i]) mem[i][wptr[i]] <= push_ent[i];
   end

   // FIFO pointers and occupancy; push+pop leaves count unchanged
   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (push[i]) wptr[i] <= wptr[i] + 1'b1;
            if (pop[i])  rptr[i] <= rptr[i] + 1'b1;
            if (push[i] && !pop[i])      cnt[i] <= cnt[i] + 1'b1;
            else if (pop[i] && !push[i]) cnt[i] <= cnt[i] - 1'b1;
         end
      end
   end

   // config registers and registered threshold IRQ
   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         tx_dest <= '0;
         irq_thr <= '0;
         irq_o   <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (wr_dest[i])
               tx_dest[i] <= (N > 1) ? SRC_W'(pwdata_i[i]) : '0;
            if (wr_thr[i])
               irq_thr[i] <= CNT_W'(pwdata_i[i]);
            irq_o[i] <= (irq_thr[i] != '0) && (cnt[i] >= irq_thr[i]);
         end
      end
   end

`ifdef MAILBOX_DROP_CNT_EN
   // saturating drop counters; a clear wins over a same-cycle drop
   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         drop_cnt <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (clr_drop[i])
               drop_cnt[i] <= '0;
            else if (drop_inc[i] && (drop_cnt[i] != 16'hFFFF))
               drop_cnt[i] <= drop_cnt[i] + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mailbox_mc_apb.sv
// Bench for mailbox_mc_apb: directed scenarios then random
// APB traffic on all ports against a queue-based model.
module tb_mailbox_mc_apb;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int AW = 8;
   localparam int K  = 16;

   logic clk = 1'b0;
   logic rst_n;
   logic [N-1:0]         psel, pen, pwr, pready, pslverr, irq;
   logic [N-1:0][AW-1:0] paddr;
   logic [N-1:0][W-1:0]  pwdata, prdata;

   int n_cmp;
   int n_bad;

   always #5 clk = ~clk;

   mailbox_mc_apb #(
      .N_NUMB_CPU   (N),
      .W_WIDTH_SYS  (W),
      .WIDTH_ADDR   (AW),
      .K_FIFO_DEPTH (K)
   ) dut (
      .pclk_i    (clk),
      .presetn_i (rst_n),
      .psel_i    (psel),
      .penable_i (pen),
      .pwrite_i  (pwr),
      .paddr_i   (paddr),
      .pwdata_i  (pwdata),
      .prdata_o  (prdata),
      .pready_o  (pready),
      .pslverr_o (pslverr),
      .irq_o     (irq)
   );

   typedef struct {
      int          src;
      logic [31:0] data;
   } ent_t;

   ent_t        fq [N][$];
   int          m_dest [N];
   int          m_thr  [N];
   int          m_drop [N];
   bit          m_irq  [N];
   int          m_rr;
   bit          l_rdy  [N];
   logic [31:0] o_rd   [N];
   bit          o_err  [N];

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < N; i++) begin
         fq[i].delete();
         m_dest[i] = 0;
         m_thr[i]  = 0;
         m_drop[i] = 0;
         m_irq[i]  = 1'b0;
         l_rdy[i]  = 1'b0;
      end
      m_rr = 0;
   endtask

   function automatic logic [31:0] m_status(int i);
      logic [31:0] s;
      s     = 32'(fq[i].size());
      s[16] = (fq[i].size() == 0);
      s[17] = (fq[i].size() == K);
      s[18] = (fq[m_dest[i]].size() == K);
      return s;
   endfunction

   // evaluate one clock of the mailbox rules, compare, then advance
   task automatic step();
      bit          e_rdy [N];
      bit          e_err [N];
      logic [31:0] e_rd  [N];
      bit          pop [N];
      bit          rq  [N];
      bit          clr [N];
      bit          wd  [N];
      bit          wt  [N];
      int          nd  [N];
      int          nt  [N];
      bit          nirq [N];
      int          g, d, drop_to;
      bit          do_push;
      ent_t        pe;
      g = -1; d = 0; drop_to = -1; do_push = 1'b0;
      pe.src = 0; pe.data = '0;
      for (int i = 0; i < N; i++) begin
         e_rdy[i] = 0; e_err[i] = 0; e_rd[i] = '0;
         pop[i] = 0; rq[i] = 0; clr[i] = 0;
         wd[i] = 0; wt[i] = 0; nd[i] = 0; nt[i] = 0;
      end
      for (int i = 0; i < N; i++) begin
         if (psel[i] && pen[i]) begin
            e_rdy[i] = 1'b1;
            case (int'(paddr[i]))
               'h00: if (pwr[i]) begin rq[i] = 1; e_rdy[i] = 0; end
                     else e_err[i] = 1;
               'h04: if (pwr[i]) begin wd[i] = 1; nd[i] = int'(pwdata[i] % N); end
                     else e_rd[i] = 32'(m_dest[i]);
               'h08: if (pwr[i] || fq[i].size() == 0) e_err[i] = 1;
                     else begin e_rd[i] = fq[i][0].data; pop[i] = 1; end
               'h0C: if (pwr[i]) e_err[i] = 1;
                     else e_rd[i] = m_status(i);
               'h10: if (pwr[i]) begin wt[i] = 1; nt[i] = int'(pwdata[i] % (2 * K)); end
                     else e_rd[i] = 32'(m_thr[i]);
               'h14: if (pwr[i]) e_err[i] = 1;
                     else if (fq[i].size() > 0) e_rd[i] = 32'(fq[i][0].src);
`ifdef MAILBOX_DROP_CNT_EN
               'h18: if (pwr[i]) clr[i] = 1;
                     else e_rd[i] = 32'(m_drop[i]);
`endif
               default: e_err[i] = 1;
            endcase
         end
      end
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_rr + k) % N;
         if (g < 0 && rq[j]) g = j;
      end
      if (g >= 0) begin
         e_rdy[g] = 1'b1;
         d = m_dest[g];
         if (fq[d].size() == K) begin
            e_err[g] = 1'b1;
            drop_to  = d;
         end else begin
            do_push = 1'b1;
            pe.src  = g;
            pe.data = pwdata[g];
         end
         m_rr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
         chk($sformatf("p%0d_ready", i), 32'(pready[i]), 32'(e_rdy[i]));
         chk($sformatf("p%0d_slverr", i), 32'(pslverr[i]), 32'(e_err[i]));
         chk($sformatf("p%0d_prdata", i), prdata[i], e_rd[i]);
         chk($sformatf("p%0d_irq", i), 32'(irq[i]), 32'(m_irq[i]));
         l_rdy[i] = e_rdy[i];
         if (e_rdy[i]) begin
            o_rd[i]  = prdata[i];
            o_err[i] = pslverr[i];
         end
      end
      for (int i = 0; i < N; i++)
         nirq[i] = (m_thr[i] != 0) && (fq[i].size() >= m_thr[i]);
      for (int i = 0; i < N; i++)
         if (pop[i]) void'(fq[i].pop_front());
      if (do_push) fq[d].push_back(pe);
      if (drop_to >= 0 && m_drop[drop_to] < 65535) m_drop[drop_to]++;
      for (int i = 0; i < N; i++) begin
         if (wd[i])  m_dest[i] = nd[i];
         if (wt[i])  m_thr[i]  = nt[i];
         if (clr[i]) m_drop[i] = 0;
         m_irq[i] = nirq[i];
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      step();
      @(posedge clk);
      #1;
   endtask

   task automatic apb(int p, bit w, int a, logic [31:0] d);
      psel[p]   = 1'b1;
      pen[p]    = 1'b0;
      pwr[p]    = w;
      paddr[p]  = AW'(a);
      pwdata[p] = d;
      cycle();
      pen[p] = 1'b1;
      for (int t = 0; t < 40; t++) begin
         cycle();
         if (l_rdy[p]) break;
      end
      chk("apb_timeout", 32'(l_rdy[p]), 32'd1);
      psel[p] = 1'b0;
      pen[p]  = 1'b0;
   endtask

   task automatic pick(int i);
      int r;
      r         = int'($urandom_range(15));
      pwdata[i] = $urandom;
      pwr[i]    = 1'b1;
      if (r < 6) paddr[i] = 8'h00;
      else if (r < 10) begin pwr[i] = 0; paddr[i] = 8'h08; end
      else if (r == 10) paddr[i] = 8'h04;
      else if (r == 11) begin
         paddr[i] = 8'h10;
         if ($urandom_range(3) != 0) pwdata[i] = 32'($urandom_range(6));
      end
      else if (r == 12) begin pwr[i] = 0; paddr[i] = 8'h0C; end
      else if (r == 13) begin pwr[i] = 0; paddr[i] = 8'h14; end
      else begin
         pwr[i]   = 1'(r & 1);
         paddr[i] = AW'($urandom_range(8) * 4);
      end
   endtask

   initial begin
      int ord [3];
      int st  [N];
      int pc  [3];
      ord = '{0, 1, 3};
      pc  = '{0, 1, 3};
      n_cmp = 0; n_bad = 0;
      psel = '0; pen = '0; pwr = '0; paddr = '0; pwdata = '0;
      rst_n = 1'b0;
      m_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      cycle();

      for (int i = 0; i < N; i++) begin
         apb(i, 0, 'h0C, 0);
         chk($sformatf("rst_status%0d", i), o_rd[i], 32'h0001_0000);
      end
      chk("rst_irq", 32'(irq), 32'd0);

      apb(0, 1, 'h04, 2);
      apb(1, 1, 'h04, 32'hFFFF_FFF6);
      apb(3, 1, 'h04, 2);
      apb(1, 0, 'h04, 0);
      chk("dest_trunc", o_rd[1], 32'd2);

      foreach (pc[k]) begin
         psel[pc[k]] = 1; pen[pc[k]] = 0; pwr[pc[k]] = 1;
         paddr[pc[k]] = 8'h00; pwdata[pc[k]] = 32'hC0DE_0000 + 32'(pc[k]);
      end
      cycle();
      foreach (pc[k]) pen[pc[k]] = 1;
      for (int t = 0; t < 20; t++) begin
         cycle();
         for (int i = 0; i < N; i++)
            if (l_rdy[i]) begin psel[i] = 0; pen[i] = 0; end
         if (psel == '0) break;
      end
      chk("conc_done", 32'(psel), 32'd0);
      psel = '0; pen = '0;
      for (int k = 0; k < 3; k++) begin
         apb(2, 0, 'h14, 0);
         chk($sformatf("rr_src%0d", k), o_rd[2], 32'(ord[k]));
         apb(2, 0, 'h08, 0);
         chk($sformatf("rr_data%0d", k), o_rd[2], 32'hC0DE_0000 + 32'(ord[k]));
      end

      apb(0, 1, 'h00, 32'hA5A5_0001);
      apb(2, 0, 'h0C, 0);
      chk("one_status", o_rd[2], 32'h0000_0001);
      apb(2, 0, 'h14, 0);
      chk("one_src", o_rd[2], 32'd0);
      apb(2, 0, 'h08, 0);
      chk("one_data", o_rd[2], 32'hA5A5_0001);
      apb(2, 0, 'h0C, 0);
      chk("one_empty", o_rd[2], 32'h0001_0000);

      apb(0, 1, 'h04, 1);
      for (int k = 0; k < K; k++) apb(0, 1, 'h00, $urandom);
      apb(0, 1, 'h00, 32'hDEAD_0017);
      chk("full_err", 32'(o_err[0]), 32'd1);
      apb(1, 0, 'h0C, 0);
      chk("full_status", o_rd[1], 32'h0002_0010);
`ifdef MAILBOX_DROP_CNT_EN
      apb(0, 1, 'h00, 32'hDEAD_0018);
      apb(1, 0, 'h18, 0);
      chk("drop_cnt", o_rd[1], 32'd2);
      apb(1, 1, 'h18, 0);
      apb(1, 0, 'h18, 0);
      chk("drop_clr", o_rd[1], 32'd0);
`else
      apb(1, 0, 'h18, 0);
      chk("drop_unmapped", 32'(o_err[1]), 32'd1);
`endif
      for (int k = 0; k < K; k++) apb(1, 0, 'h08, 0);
      apb(1, 0, 'h08, 0);
      chk("empty_data", o_rd[1], 32'd0);
      chk("empty_err", 32'(o_err[1]), 32'd1);

      apb(3, 1, 'h10, 32'hFFFF_FFE3);
      apb(3, 0, 'h10, 0);
      chk("thr_trunc", o_rd[3], 32'd3);
      apb(0, 1, 'h04, 3);
      for (int k = 0; k < 3; k++) apb(0, 1, 'h00, 32'h1000 + 32'(k));
      chk("irq_pre", 32'(irq[3]), 32'd0);
      cycle();
      chk("irq_rise", 32'(irq[3]), 32'd1);
      apb(3, 0, 'h08, 0);
      chk("irq_hold", 32'(irq[3]), 32'd1);
      cycle();
      chk("irq_fall", 32'(irq[3]), 32'd0);

      for (int i = 0; i < N; i++) st[i] = 0;
      for (int c = 0; c < 3000; c++) begin
         cycle();
         for (int i = 0; i < N; i++) begin
            case (st[i])
               0: if ($urandom_range(2) == 0) begin
                     pick(i);
                     psel[i] = 1; pen[i] = 0; st[i] = 1;
                  end
               1: begin pen[i] = 1; st[i] = 2; end
               default:
                  if (l_rdy[i] || $urandom_range(9) == 0) begin
                     psel[i] = 0; pen[i] = 0; st[i] = 0;
                  end
            endcase
         end
      end

      rst_n = 1'b0;
      psel = '0; pen = '0;
      m_reset();
      @(negedge clk);
      chk("rst_mid_ready", 32'(pready), 32'd0);
      chk("rst_mid_irq", 32'(irq), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cycle();
      for (int i = 0; i < N; i++) begin
         apb(i, 0, 'h0C, 0);
         chk($sformatf("rst_mid_status%0d", i), o_rd[i], 32'h0001_0000);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
